// File: rtl/bpm_beat_generator.sv
// Metronome beat generator: divides 60*CLK_FREQ_HZ by a clamped BPM to get the beat period.
// Optional eighth-note output o_subbeat is enabled by defining BPM_SUBDIV_EN.
module bpm_beat_generator #(
    parameter int unsigned CLK_FREQ_HZ   = 50000000,
    parameter int unsigned BPM_MIN       = 30,
    parameter int unsigned BPM_MAX       = 300,
    parameter int unsigned DEFAULT_BPM   = 120,
    parameter int unsigned BEATS_PER_BAR = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic [8:0]  i_bpm,
    input  logic        i_bpm_load,
    output logic        o_beat,
    output logic        o_bar_start,
    output logic [2:0]  o_beat_idx,
    output logic        o_busy,
`ifdef BPM_SUBDIV_EN
    output logic        o_subbeat,
`endif
    output logic [31:0] o_period
);

    localparam logic [31:0] DIVIDEND       = 32'(60 * CLK_FREQ_HZ);
    localparam logic [31:0] DEFAULT_PERIOD = DIVIDEND / 32'(DEFAULT_BPM);
    localparam logic [8:0]  BPM_LO         = 9'(BPM_MIN);
    localparam logic [8:0]  BPM_HI         = 9'(BPM_MAX);
    localparam logic [2:0]  LAST_IDX       = 3'(BEATS_PER_BAR - 1);

    typedef enum logic [1:0] {StIdle, StDiv, StDone} div_state_e;

    div_state_e  state_q;
    logic        busy_q;
    logic [8:0]  divisor_q;
    logic [31:0] dvd_q, dvd_d;
    logic [8:0]  rem_q, rem_d;
    logic [4:0]  bit_cnt_q;
    logic [31:0] pending_q;
    logic [8:0]  bpm_clamped;
    logic [9:0]  rem_shift;
    logic        rem_ge;

    always_comb begin
        bpm_clamped = i_bpm;
        if (i_bpm < BPM_LO) begin
            bpm_clamped = BPM_LO;
        end else if (i_bpm > BPM_HI) begin
            bpm_clamped = BPM_HI;
        end
    end

    // Restoring step: dvd_q shifts its MSB into the remainder while quotient bits shift in.
    always_comb begin
        rem_shift = {rem_q, dvd_q[31]};
        rem_ge    = rem_shift >= {1'b0, divisor_q};
        rem_d     = rem_ge ? 9'(rem_shift - {1'b0, divisor_q}) : rem_shift[8:0];
        dvd_d     = {dvd_q[30:0], rem_ge};
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            divisor_q <= BPM_HI;
            dvd_q     <= '0;
            rem_q     <= '0;
            bit_cnt_q <= '0;
            pending_q <= DEFAULT_PERIOD;
        end else if (i_bpm_load) begin
            // A load always wins, aborting any computation in flight.
            state_q   <= StDiv;
            busy_q    <= 1'b1;
            divisor_q <= bpm_clamped;
            dvd_q     <= DIVIDEND;
            rem_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                end
                StDiv: begin
                    dvd_q     <= dvd_d;
                    rem_q     <= rem_d;
                    bit_cnt_q <= bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    pending_q <= dvd_q;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    logic        run_q;
    logic        beat_q, beat_d;
    logic        bar_q, bar_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        start, due;

    // cnt_q is 1 in the beat cycle, so a beat is due once it reaches the period.
    always_comb begin
        start    = i_run && !run_q;
        due      = run_q && (cnt_q >= period_q);
        beat_d   = i_run && (start || due);
        idx_d    = idx_q;
        cnt_d    = cnt_q + 32'd1;
        period_d = period_q;
        if (!i_run || start) begin
            idx_d = '0;
        end else if (due) begin
            idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end
        if (!i_run) begin
            cnt_d = '0;
        end else if (beat_d) begin
            cnt_d    = 32'd1;
            period_d = pending_q;
        end
        bar_d = beat_d && (idx_d == 3'd0);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            run_q    <= 1'b0;
            beat_q   <= 1'b0;
            bar_q    <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            period_q <= DEFAULT_PERIOD;
        end else begin
            run_q    <= i_run;
            beat_q   <= beat_d;
            bar_q    <= bar_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

`ifdef BPM_SUBDIV_EN
    logic sub_q, sub_d;

    always_comb begin
        sub_d = i_run && run_q && !due && (cnt_q == {1'b0, period_q[31:1]});
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end

    assign o_subbeat = sub_q;
`endif

    assign o_beat      = beat_q;
    assign o_bar_start = bar_q;
    assign o_beat_idx  = idx_q;
    assign o_busy      = busy_q;
    assign o_period    = period_q;

endmodule

// File: tb/tb_bpm_beat_generator.sv
// Scoreboard bench for bpm_beat_generator at CLK_FREQ_HZ=1000, BEATS_PER_BAR=3.
module tb_bpm_beat_generator;

    logic        clk = 1'b0;
    logic        i_reset, i_run, i_bpm_load;
    logic [8:0]  i_bpm;
    logic        o_beat, o_bar_start, o_busy;
    logic [2:0]  o_beat_idx;
    logic [31:0] o_period;
`ifdef BPM_SUBDIV_EN
    logic        o_subbeat;
`endif

    bpm_beat_generator #(
        .CLK_FREQ_HZ  (1000),
        .BPM_MIN      (30),
        .BPM_MAX      (300),
        .DEFAULT_BPM  (120),
        .BEATS_PER_BAR(3)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_run      (i_run),
        .i_bpm      (i_bpm),
        .i_bpm_load (i_bpm_load),
        .o_beat     (o_beat),
        .o_bar_start(o_bar_start),
        .o_beat_idx (o_beat_idx),
        .o_busy     (o_busy),
`ifdef BPM_SUBDIV_EN
        .o_subbeat  (o_subbeat),
`endif
        .o_period   (o_period)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   t;
        int   idx;
        logic bar;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;
    int    checks = 0;
    int    failures = 0;
    int    t0, t1, t2, t3, n;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_beat(input int t, input int idx, input logic bar);
        beat_t b;
        b.t   = t;
        b.idx = idx;
        b.bar = bar;
        exp_q.push_back(b);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic load_bpm(input logic [8:0] v);
        int cnt;
        i_bpm      = v;
        i_bpm_load = 1'b1;
        @(negedge clk);
        i_bpm_load = 1'b0;
        cnt = 0;
        while (o_busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_len", cnt, 33);
    endtask

    // Monitor: every observed beat is matched against the next expected one.
    always @(negedge clk) begin
        if (i_reset) begin
            if (exp_q.size() > 0 && cyc > exp_q[0].t) begin
                mon_b = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_beat: no beat observed, expected at cycle %0d", mon_b.t);
            end
            if (o_beat) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: beat at cycle %0d, expected none", cyc);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat_cycle", cyc, mon_b.t);
                    check("beat_idx", o_beat_idx, mon_b.idx);
                    check("bar_start", o_bar_start, mon_b.bar);
                end
            end else if (o_bar_start) begin
                check("bar_without_beat", o_bar_start, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset    = 1'b0;
        i_run      = 1'b0;
        i_bpm      = '0;
        i_bpm_load = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_beat", o_beat, 0);
        check("rst_bar", o_bar_start, 0);
        check("rst_idx", o_beat_idx, 0);
        check("rst_busy", o_busy, 0);
        check("rst_period", o_period, 500);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);

        // 120 BPM, bar of 3: idx 0,1,2,0,1,2,0
        t0    = cyc;
        i_run = 1'b1;
        for (int k = 0; k < 7; k++) push_beat(t0 + 1 + 500 * k, k % 3, (k % 3) == 0);
        @(negedge clk);
        check("period_120", o_period, 500);

        // 60 BPM loaded mid-interval: current interval stays 500
        wait_until(t0 + 3101);
        load_bpm(9'd60);
        check("period_hold", o_period, 500);
        push_beat(t0 + 3501, 1, 1'b0);
        push_beat(t0 + 4501, 2, 1'b0);
        push_beat(t0 + 5501, 0, 1'b1);
        wait_until(t0 + 3502);
        check("period_60", o_period, 1000);

        // Stop, load 0 (clamped to 30 BPM), restart
        wait_until(t0 + 5600);
        i_run = 1'b0;
        @(negedge clk);
        check("idx_stopped", o_beat_idx, 0);
        load_bpm(9'd0);
        check("period_stopped", o_period, 1000);
        t1    = cyc;
        i_run = 1'b1;
        push_beat(t1 + 1, 0, 1'b1);
        push_beat(t1 + 2001, 1, 1'b0);
        wait_until(t1 + 2);
        check("period_30", o_period, 2000);

        // Load 400 (clamped to 300), then drop run exactly when a beat is due
        wait_until(t1 + 2100);
        load_bpm(9'd400);
        check("period_hold_30", o_period, 2000);
        wait_until(t1 + 4000);
        i_run = 1'b0;
        @(negedge clk);
        check("beat_suppressed", o_beat, 0);
        check("idx_cleared", o_beat_idx, 0);
        wait_until(t1 + 4010);
        t2    = cyc;
        i_run = 1'b1;
        push_beat(t2 + 1, 0, 1'b1);
        push_beat(t2 + 201, 1, 1'b0);
        push_beat(t2 + 401, 2, 1'b0);
        push_beat(t2 + 601, 0, 1'b1);
        push_beat(t2 + 801, 1, 1'b0);
        push_beat(t2 + 1201, 2, 1'b0);
        wait_until(t2 + 2);
        check("period_300", o_period, 200);

        // 90 BPM aborted by 150 BPM ten cycles later; 666 must never be applied
        wait_until(t2 + 560);
        i_bpm      = 9'd90;
        i_bpm_load = 1'b1;
        @(negedge clk);
        i_bpm_load = 1'b0;
        wait_until(t2 + 570);
        check("busy_between_loads", o_busy, 1);
        load_bpm(9'd150);
        check("period_after_abort", o_period, 200);
        wait_until(t2 + 802);
        check("period_150", o_period, 400);

        // Reset mid-division and mid-interval
        wait_until(t2 + 1300);
        i_bpm      = 9'd60;
        i_bpm_load = 1'b1;
        @(negedge clk);
        i_bpm_load = 1'b0;
        wait_until(t2 + 1310);
        #2;
        i_reset = 1'b0;
        i_run   = 1'b0;
        #1;
        check("mid_rst_beat", o_beat, 0);
        check("mid_rst_bar", o_bar_start, 0);
        check("mid_rst_idx", o_beat_idx, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_period", o_period, 500);
        @(negedge clk);
        i_reset = 1'b1;
        repeat (50) @(negedge clk);
        check("post_rst_busy", o_busy, 0);
        t3    = cyc;
        i_run = 1'b1;
        push_beat(t3 + 1, 0, 1'b1);
        push_beat(t3 + 501, 1, 1'b0);
        wait_until(t3 + 502);
        check("post_rst_period", o_period, 500);

        repeat (5) @(negedge clk);
        n = exp_q.size();
        check("queue_empty", n, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
